// File: rtl/io_bank.sv
// rtl/io_bank.sv - bidirectional pad bank with output registers, input synchroniser,
// per-bit glitch filter and sticky edge flags
module io_bank #(
  parameter int W           = 8,
  parameter int SYNC_OUT    = 0,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] out,
  input  logic [W-1:0] oe,
  output logic [W-1:0] in,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall,
  input  logic [W-1:0] edge_clr,
  inout  wire  [W-1:0] pad
);

  logic [W-1:0] out_pad;
  logic [W-1:0] oe_pad;
  logic [W-1:0] sync;
  logic [W-1:0] prev_q;
  logic [W-1:0] rise_q, rise_d;
  logic [W-1:0] fall_q, fall_d;

  if (SYNC_OUT != 0) begin : g_out_reg
    logic [W-1:0] out_q;
    logic [W-1:0] oe_q;

    // Cleared enables keep every pad released while reset is held.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q <= '0;
        oe_q  <= '0;
      end else begin
        out_q <= out;
        oe_q  <= oe;
      end
    end

    assign out_pad = out_q;
    assign oe_pad  = oe_q;
  end else begin : g_out_comb
    assign out_pad = out;
    assign oe_pad  = oe;
  end

  for (genvar i = 0; i < W; i++) begin : g_pad
    assign pad[i] = oe_pad[i] ? out_pad[i] : 1'bz;
  end

  if (SYNC_STAGES == 0) begin : g_sync_bypass
    assign sync = pad;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= pad;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync_q[k] <= sync_q[k-1];
        end
      end
    end

    assign sync = sync_q[SYNC_STAGES-1];
  end

  if (FILTER_LEN == 0) begin : g_filt_bypass
    assign in = sync;
  end else begin : g_filt
    localparam int            CW       = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [W-1:0]         filt_q, filt_d;
    logic [W-1:0][CW-1:0] cnt_q, cnt_d;

    // A mismatch must survive FILTER_LEN consecutive edges; any agreement restarts it.
    always_comb begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
      for (int i = 0; i < W; i++) begin
        if (sync[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        filt_q <= '0;
        cnt_q  <= '0;
      end else begin
        filt_q <= filt_d;
        cnt_q  <= cnt_d;
      end
    end

    assign in = filt_q;
  end

  // Set has priority over a coincident clear.
  always_comb begin
    rise_d = (rise_q & ~edge_clr) | (in & ~prev_q);
    fall_d = (fall_q & ~edge_clr) | (~in & prev_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      prev_q <= in;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule
